dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the pipelined processor's memory stage and a secondary bus master, such as a VGA/sprite fetch engine or a DMA copier. The processor port has fixed priority. An aging counter guarantees the secondary master a grant after a bounded wait. The block sits between the processor's dmem outputs and the dmem instance in the wrapper. It also returns read data to whichever requester issued the read.

## Interface
- ADDR_W, 12, word address width presented to dmem
- DATA_W, 32, data width
- MAX_WAIT, 4, number of consecutive denied DMA request cycles before DMA is force-granted (range 1..15)

Ports:
- clock  in  1  master clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock
- cpu_req  in  1  processor requests a dmem access this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  processor word address
- cpu_wdata  in  DATA_W  processor write data
- cpu_gnt  out  1  processor access accepted this cycle (combinational)
- cpu_rvalid  out  1  processor read data valid (registered)
- cpu_rdata  out  DATA_W  processor read data
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  secondary master request, same meaning as the cpu_* inputs
- dma_gnt  out  1  secondary access accepted this cycle (combinational)
- dma_rvalid  out  1  secondary read data valid (registered)
- dma_rdata  out  DATA_W  secondary read data
- mem_addr  out  ADDR_W  to dmem address
- mem_wdata  out  DATA_W  to dmem write data
- mem_wren  out  1  to dmem write enable
- mem_q  in  DATA_W  dmem read data, valid one cycle after its address was presented

## Operation
- **Transfer rule.** A transfer occurs in any cycle where a request and its grant are both high. At most one grant is high per cycle.
- **Arbitration, normal state (PRI_CPU):**
  - cpu_gnt = cpu_req.
  - dma_gnt = dma_req & ~cpu_req.
- **Arbitration, forced state (FORCE_DMA):** entered when the wait counter reaches MAX_WAIT.
  - dma_gnt = dma_req.
  - cpu_gnt = cpu_req & ~dma_req.
- **Wait counter (4 bits):**
  - Increments on each cycle with dma_req=1 and dma_gnt=0, saturating at MAX_WAIT.
  - Clears on any dma grant, or on any cycle with dma_req=0.
- **State transitions:**
  - PRI_CPU -> FORCE_DMA when the counter equals MAX_WAIT at a clock edge.
  - FORCE_DMA -> PRI_CPU after exactly one DMA transfer.
  - FORCE_DMA -> PRI_CPU if dma_req drops before the DMA transfer occurs.
- **Memory mux (combinational):**
  - mem_addr/mem_wdata come from the granted requester.
  - mem_wren = (granted requester's we) & (grant).
  - With no grant: mem_wren=0, and mem_addr holds cpu_addr.
- **Read return path:**
  - A registered 2-bit tag {rd_cpu, rd_dma} records which requester performed a read transfer.
  - The next cycle, the matching *_rvalid is 1 and *_rdata = mem_q.
  - The non-matching rdata reads 0.
- **Writes** never produce an rvalid.
- **Cycle independence:** back-to-back transfers are allowed every cycle; no bubbles are inserted.

## Timing
- **Grant latency:** 0 cycles (grant is combinational from req and state).
- **Read latency:** 1 cycle; rvalid is high for exactly one cycle per read transfer.
- **Write latency:** the write commits on the rising edge that ends the grant cycle.
- **Reset (reset=0 at an edge):**
  - State = PRI_CPU, counter = 0, tags = 0.
  - cpu_rvalid and dma_rvalid are 0 in the following cycle.
- **Grants and writes while reset is asserted:** cpu_gnt, dma_gnt and mem_wren are forced to 0 combinationally.
- **Reset mid-read:** a read granted in the cycle reset is sampled produces no rvalid.
- **Simultaneous requests:**
  - PRI_CPU: the CPU wins.
  - FORCE_DMA: the DMA wins. The CPU is denied for that single cycle, and the CPU's own pipeline hold is its responsibility.
- **Worst-case DMA wait** with cpu_req held high: MAX_WAIT denied cycles, then a grant on cycle MAX_WAIT+1.
- **Counter saturation:** the counter never exceeds MAX_WAIT, and never wraps.

## Test plan
- **Reset:** hold reset=0 for 2 cycles with both req=1 -> gnts=0, mem_wren=0; after release, cycle 1 gives cpu_gnt=1, and both rvalid stay 0 until a read completes.
- **CPU-only traffic:**
  - CPU write addr 0x010 data 0xDEADBEEF -> mem_wren=1, mem_addr=0x010 that cycle.
  - CPU read 0x010 next cycle -> cpu_rvalid=1 with cpu_rdata=0xDEADBEEF one cycle later, and dma_rvalid=0.
- **Starvation limit:** cpu_req=1 continuously and dma_req=1 reading 0x020, MAX_WAIT=4 -> dma_gnt=0 for cycles 1-4, then dma_gnt=1 and cpu_gnt=0 on cycle 5; dma_rvalid on cycle 6; cpu_gnt=1 again on cycle 6.
- **Idle DMA:** only dma_req=1 with alternating read/write to 0x3FF -> dma_gnt=1 every cycle, counter stays 0.
- **Interleaved reads:** CPU read 0x001 at cycle n, DMA read 0x002 at n+1 -> cpu_rvalid at n+1 and dma_rvalid at n+2, each carrying its own mem_q value.
- **Abort and reset:**
  - dma_req drops in the FORCE_DMA cycle -> state returns to PRI_CPU, cpu_gnt=1.
  - reset asserted during an outstanding read -> no rvalid.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle between the processor/DMA requesters, the data memory and the arbiter.
// Debug taps expose the arbiter's state and its wait counter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // A request transfers in any cycle where *_req and *_gnt are both high.
  // The grant is combinational and the requester may drop or change its request after any cycle.
  // Read data returns exactly one cycle later with a one-cycle *_rvalid pulse.
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
  logic              dbg_state;
  logic [3:0]        dbg_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_q,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_wdata, mem_wren,
    output dbg_state, dbg_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_q,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wdata, mem_wren,
    input  dbg_state, dbg_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU has fixed priority, and an aging counter
// force-grants the DMA master after MAX_WAIT consecutive denied cycles.
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input logic            clock,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);
  typedef enum logic {
    PRI_CPU   = 1'b0,
    FORCE_DMA = 1'b1
  } state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_WAIT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_rd_cpu;
  logic       r_rd_dma;
  logic       w_cpu_gnt;
  logic       w_dma_gnt;

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    if (reset) begin
      if (r_state == FORCE_DMA) begin
        w_dma_gnt = bus.dma_req;
        w_cpu_gnt = bus.cpu_req & ~bus.dma_req;
      end else begin
        w_cpu_gnt = bus.cpu_req;
        w_dma_gnt = bus.dma_req & ~bus.cpu_req;
      end
    end
  end

  // FORCE_DMA is entered on the edge at which the counter becomes MAX_WAIT,
  // so the forced grant lands on denied-cycle MAX_WAIT+1.
  always_comb begin
    w_cnt_nxt   = 4'd0;
    w_state_nxt = PRI_CPU;
    if (bus.dma_req && !w_dma_gnt) begin
      w_cnt_nxt = (r_cnt >= LP_MAX) ? LP_MAX : r_cnt + 4'd1;
    end
    if (r_state == PRI_CPU && w_cnt_nxt == LP_MAX) begin
      w_state_nxt = FORCE_DMA;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= PRI_CPU;
      r_cnt    <= 4'd0;
      r_rd_cpu <= 1'b0;
      r_rd_dma <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rd_cpu <= w_cpu_gnt & ~bus.cpu_we;
      r_rd_dma <= w_dma_gnt & ~bus.dma_we;
    end
  end

  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.dma_gnt    = w_dma_gnt;
  assign bus.mem_addr   = w_dma_gnt ? bus.dma_addr  : bus.cpu_addr;
  assign bus.mem_wdata  = w_dma_gnt ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.mem_wren   = (w_cpu_gnt & bus.cpu_we) | (w_dma_gnt & bus.dma_we);
  assign bus.cpu_rvalid = r_rd_cpu;
  assign bus.dma_rvalid = r_rd_dma;
  assign bus.cpu_rdata  = r_rd_cpu ? bus.mem_q : '0;
  assign bus.dma_rdata  = r_rd_dma ? bus.mem_q : '0;
  assign bus.dbg_state  = r_state;
  assign bus.dbg_cnt    = r_cnt;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter: a queue-based reference model
// checks every cycle, and literal expectations pin down the key scenarios.
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory stand-in with a one-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_q <= mem[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: streak counts consecutive denied DMA request cycles.
  int            streak = 0;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW:0]   cpu_q [$];
  logic [DW:0]   dma_q [$];

  always @(negedge clock) begin : model
    logic          force_now;
    logic          ecg;
    logic          edg;
    logic          ewren;
    logic [AW-1:0] a;
    logic [DW:0]   e;
    force_now = (streak == MW);
    ecg = 1'b0;
    edg = 1'b0;
    if (reset) begin
      if (force_now) begin
        edg = bus.dma_req;
        ecg = bus.cpu_req & ~bus.dma_req;
      end else begin
        ecg = bus.cpu_req;
        edg = bus.dma_req & ~bus.cpu_req;
      end
    end
    ewren = (ecg & bus.cpu_we) | (edg & bus.dma_we);
    a = edg ? bus.dma_addr : bus.cpu_addr;
    chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(ecg));
    chk("dma_gnt", 32'(bus.dma_gnt), 32'(edg));
    chk("mem_wren", 32'(bus.mem_wren), 32'(ewren));
    chk("mem_addr", 32'(bus.mem_addr), 32'(a));
    if (ewren) chk("mem_wdata", bus.mem_wdata, edg ? bus.dma_wdata : bus.cpu_wdata);
    chk("dbg_cnt", 32'(bus.dbg_cnt), 32'(streak));
    chk("dbg_state", 32'(bus.dbg_state), 32'(force_now));
    if (cpu_q.size() != 0) begin
      e = cpu_q.pop_front();
      chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
      if (e[DW]) chk("cpu_rdata", bus.cpu_rdata, e[DW-1:0]);
    end else begin
      chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      chk("cpu_rdata_idle", bus.cpu_rdata, 32'd0);
    end
    if (dma_q.size() != 0) begin
      e = dma_q.pop_front();
      chk("dma_rvalid", 32'(bus.dma_rvalid), 32'd1);
      if (e[DW]) chk("dma_rdata", bus.dma_rdata, e[DW-1:0]);
    end else begin
      chk("dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
      chk("dma_rdata_idle", bus.dma_rdata, 32'd0);
    end
    if (!reset) streak = 0;
    else if (bus.dma_req && !edg) streak = streak + 1;
    else streak = 0;
    if (ewren) begin
      ref_mem[a] = edg ? bus.dma_wdata : bus.cpu_wdata;
    end else if (ecg || edg) begin
      e = ref_mem.exists(a) ? {1'b1, ref_mem[a]} : '0;
      if (ecg) cpu_q.push_back(e);
      else dma_q.push_back(e);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clock);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic cpu_write(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    drive(1'b1, 1'b1, ad, d, 1'b0, 1'b0, '0, '0);
    cyc();
  endtask

  initial begin
    // Reset with both requesters active.
    drive(1'b1, 1'b0, 12'h000, '0, 1'b1, 1'b0, 12'h000, '0);
    reset = 1'b0;
    repeat (2) begin
      at_sample();
      chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
      chk("rst_dma_gnt", 32'(bus.dma_gnt), 32'd0);
      chk("rst_wren", 32'(bus.mem_wren), 32'd0);
      chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    end
    cyc();
    reset = 1'b1;
    at_sample();
    chk("rel_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("rel_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    chk("rel_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    cyc();

    // CPU write then read-back.
    drive(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    at_sample();
    chk("wr_wren", 32'(bus.mem_wren), 32'd1);
    chk("wr_addr", 32'(bus.mem_addr), 32'h010);
    cyc();
    drive(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b0, '0, '0);
    at_sample();
    chk("rd_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    cyc();
    idle();
    at_sample();
    chk("rd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("rd_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    chk("rd_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    cyc();

    cpu_write(12'h020, 32'hCAFEF00D);
    cpu_write(12'h001, 32'h11111111);
    cpu_write(12'h002, 32'h22222222);
    idle();
    cyc();

    // Starvation limit with the CPU requesting continuously.
    drive(1'b1, 1'b0, 12'h005, '0, 1'b1, 1'b0, 12'h020, '0);
    for (int k = 1; k <= 6; k++) begin
      at_sample();
      if (k <= 4) begin
        chk("starve_dma_gnt", 32'(bus.dma_gnt), 32'd0);
        chk("starve_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
      end else if (k == 5) begin
        chk("force_dma_gnt", 32'(bus.dma_gnt), 32'd1);
        chk("force_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        chk("force_addr", 32'(bus.mem_addr), 32'h020);
      end else begin
        chk("force_dma_rvalid", 32'(bus.dma_rvalid), 32'd1);
        chk("force_dma_rdata", bus.dma_rdata, 32'hCAFEF00D);
        chk("after_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
      end
      cyc();
    end
    idle();
    cyc();

    // DMA alone: granted every cycle, counter stays at zero.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, i[0], 12'h3FF, $urandom);
      at_sample();
      chk("idle_dma_gnt", 32'(bus.dma_gnt), 32'd1);
      chk("idle_dma_cnt", 32'(bus.dbg_cnt), 32'd0);
      cyc();
    end
    idle();
    cyc();

    // Interleaved CPU and DMA reads.
    drive(1'b1, 1'b0, 12'h001, '0, 1'b0, 1'b0, '0, '0);
    cyc();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h002, '0);
    at_sample();
    chk("il_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("il_cpu_rdata", bus.cpu_rdata, 32'h11111111);
    chk("il_dma_rvalid0", 32'(bus.dma_rvalid), 32'd0);
    cyc();
    idle();
    at_sample();
    chk("il_dma_rvalid", 32'(bus.dma_rvalid), 32'd1);
    chk("il_dma_rdata", bus.dma_rdata, 32'h22222222);
    chk("il_cpu_rvalid0", 32'(bus.cpu_rvalid), 32'd0);
    cyc();

    // DMA drops its request in the forced cycle.
    drive(1'b1, 1'b0, 12'h005, '0, 1'b1, 1'b0, 12'h3FF, '0);
    repeat (4) cyc();
    bus.dma_req = 1'b0;
    at_sample();
    chk("abort_state", 32'(bus.dbg_state), 32'd1);
    chk("abort_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("abort_dma_gnt", 32'(bus.dma_gnt), 32'd0);
    cyc();
    bus.dma_req = 1'b1;
    at_sample();
    chk("abort_state_back", 32'(bus.dbg_state), 32'd0);
    chk("abort_cpu_gnt2", 32'(bus.cpu_gnt), 32'd1);
    cyc();
    idle();
    cyc();

    // Reset while a read is requested.
    drive(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    at_sample();
    chk("rstrd_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    chk("rstrd_wren", 32'(bus.mem_wren), 32'd0);
    cyc();
    reset = 1'b1;
    idle();
    at_sample();
    chk("rstrd_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    cyc();

    // Randomized traffic with a small address pool to get read-after-write hits.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom);
      cyc();
    end
    idle();
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
